pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline buffers (IF/ID, ID/EX, EX/MEM) and the PC register. It detects load-use hazards in ID, resolves branch and jump redirects from the EX/MEM-stage control bits, and freezes the pipeline while a data-memory access is not ready. It also keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

Parameters:
TIMEOUT, 64, MEM_WAIT cycles before mem_err is set (minimum 1)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
idex_memRead  in  1  memRead bit of the ID/EX buffer
idex_rd  in  5  destination register of the ID/EX buffer
exmem_branch  in  1  branch bit of the EX/MEM buffer
exmem_zf  in  1  zero flag of the EX/MEM buffer
exmem_jump  in  1  jump bit of the EX/MEM buffer
exmem_memRead  in  1  memRead bit of the EX/MEM buffer
exmem_memWrite  in  1  memWrite bit of the EX/MEM buffer
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC load enable
pc_sel  out  2  PC source: 0 = PC+4, 1 = exmem branch_address, 2 = exmem jump_address
ifid_en, idex_en, exmem_en  out  1 each  buffer load enables
ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all control bits 0) on the next edge
mem_wait  out  1  high while in the MEM_WAIT state
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with pc_en=0 since reset (saturating)
flush_cnt  out  CNT_W  redirects since reset (saturating)

Behaviour:
- FSM has two states, RUN and MEM_WAIT. Reset moves it to RUN and clears wait_cnt, mem_err, stall_cnt and flush_cnt.
- While rst=1, outputs are forced to: all enables 0, all flushes 1, pc_sel 0, mem_wait 0.
- Outputs are combinational from state and inputs. Counters and the FSM state are registered.
- Define the following terms:
  - memacc = exmem_memRead | exmem_memWrite
  - hold = memacc & !mem_ready
  - jmp = exmem_jump
  - br = exmem_branch & exmem_zf & !exmem_jump
  - lu = idex_memRead & (idex_rd != 0) & ((idex_rd == id_rs) | (id_uses_rt & (idex_rd == id_rt)))
- Priority in RUN, and in MEM_WAIT on the cycle mem_ready=1, is: hold > redirect (jmp or br) > lu > normal.
  - hold: all enables 0, all flushes 0, pc_sel 0. Next state is MEM_WAIT. The EX/MEM buffer is frozen, so a pending redirect is re-evaluated when the hold ends.
  - redirect: all enables 1, pc_sel = 2 if jmp else 1, ifid_flush = idex_flush = exmem_flush = 1. flush_cnt increments.
  - lu: pc_en = 0, ifid_en = 0, idex_en = 1, exmem_en = 1, idex_flush = 1. Exactly one bubble is inserted per load-use hazard, and the hazard clears on the next cycle.
  - normal: all enables 1, all flushes 0, pc_sel 0.
- MEM_WAIT:
  - While mem_ready=0, apply the hold outputs and increment wait_cnt.
  - When wait_cnt reaches TIMEOUT-1 with mem_ready still 0, set mem_err to 1. mem_err stays 1 until rst. The FSM stays in MEM_WAIT.
  - When mem_ready=1, evaluate the RUN priority with hold=0, clear wait_cnt and return to RUN. There is no lost cycle: the access completes on that edge.
- A flush overrides the matching enable: a flushed buffer loads a bubble even if its enable is 1.
- stall_cnt increments every cycle pc_en=0 outside reset. Both counters saturate at 2^CNT_W - 1 and never wrap.
- A load-use hazard on register 0 never stalls. The jump+branch combination resolves as a jump.
- rst asserted mid-wait aborts the wait in the same edge; the FSM is in RUN the next cycle.

Test Plan:
- Load-use: idex_memRead=1, idex_rd=8, id_rs=8 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, stall_cnt 0->1. Next cycle with idex_memRead=0 -> all enables 1.
- Register 0: idex_memRead=1, idex_rd=0, id_rs=0 -> no stall, stall_cnt unchanged. Also id_uses_rt=0, id_rt=idex_rd=5, id_rs=3 -> no stall.
- Branch taken: exmem_branch=1, exmem_zf=1 -> pc_sel=1, three flushes high, flush_cnt=1. Jump and branch together -> pc_sel=2.
- Memory wait: exmem_memRead=1, mem_ready=0 for 3 cycles then 1 -> mem_wait high for cycles 2-4, all enables 0 for 3 cycles, stall_cnt=3, back to RUN after the ready cycle.
- Hold over redirect: exmem_jump=1, exmem_memWrite=1, mem_ready=0 for 2 cycles -> no flush during the hold. On the ready cycle -> pc_sel=2 with flushes, flush_cnt +1 only once.
- Timeout/reset: TIMEOUT=4, mem_ready held 0 -> mem_err=1 on the 4th wait cycle and it stays set. Pulse rst -> mem_err=0, counters 0, state RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline.
// Stalls on load-use hazards, redirects on EX/MEM branches and jumps,
// and freezes everything while a data-memory access is outstanding.
//
// Handshake: mem_ready is a single-cycle completion strobe. An access
// (exmem_memRead | exmem_memWrite) stays frozen in EX/MEM until a cycle
// with mem_ready=1. The access completes on that cycle's rising edge.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memRead,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_branch,
  input  logic             exmem_zf,
  input  logic             exmem_jump,
  input  logic             exmem_memRead,
  input  logic             exmem_memWrite,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mem_wait,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [WW-1:0] wait_cnt;

  logic memacc;
  logic hold;
  logic jmp;
  logic br;
  logic redirect;
  logic lu;

  // Hazard terms. In MEM_WAIT the EX/MEM buffer is frozen on a memory
  // access, so only mem_ready decides whether the hold continues.
  assign memacc   = exmem_memRead | exmem_memWrite;
  assign hold     = (state == MEM_WAIT) ? !mem_ready : (memacc & !mem_ready);
  assign jmp      = exmem_jump;
  assign br       = exmem_branch & exmem_zf & !exmem_jump;
  assign redirect = jmp | br;
  assign lu       = idex_memRead & (idex_rd != 5'd0) &
                    ((idex_rd == id_rs) | (id_uses_rt & (idex_rd == id_rt)));

  // Next state and pipeline control, priority rst > hold > redirect > lu.
  always_comb begin
    state_nx    = state;
    pc_en       = 1'b1;
    pc_sel      = 2'd0;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mem_wait    = (state == MEM_WAIT);

    if (rst) begin
      state_nx    = RUN;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      mem_wait    = 1'b0;
    end else if (hold) begin
      state_nx = MEM_WAIT;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else begin
      state_nx = RUN;
      if (redirect) begin
        pc_sel      = jmp ? 2'd2 : 2'd1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // State register, wait timer and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == MEM_WAIT && !mem_ready) begin
        if (wait_cnt != WAIT_LAST) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        if (wait_cnt == WAIT_LAST) begin
          mem_err <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (!hold && redirect && flush_cnt != {CNT_W{1'b1}}) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             idex_memRead;
  logic [4:0]       idex_rd;
  logic             exmem_branch;
  logic             exmem_zf;
  logic             exmem_jump;
  logic             exmem_memRead;
  logic             exmem_memWrite;
  logic             mem_ready;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             mem_wait;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  // {pc_en, pc_sel, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, exmem_fl, mem_wait}
  localparam logic [9:0] O_RST  = 10'b0_00_000_111_0;
  localparam logic [9:0] O_NORM = 10'b1_00_111_000_0;
  localparam logic [9:0] O_HOLD = 10'b0_00_000_000_0;
  localparam logic [9:0] O_LU   = 10'b0_00_011_010_0;
  localparam logic [9:0] O_BR   = 10'b1_01_111_111_0;
  localparam logic [9:0] O_JMP  = 10'b1_10_111_111_0;

  logic [9:0] outs;
  assign outs = {pc_en, pc_sel, ifid_en, idex_en, exmem_en,
                 ifid_flush, idex_flush, exmem_flush, mem_wait};

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_memRead(idex_memRead), .idex_rd(idex_rd),
    .exmem_branch(exmem_branch), .exmem_zf(exmem_zf), .exmem_jump(exmem_jump),
    .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
    .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_sel(pc_sel),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mem_wait(mem_wait), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combinational outputs are sampled 2 ns after the inputs change.
  task automatic chk_outs(input string tag, input logic [9:0] exp);
    #2;
    chk(tag, {22'd0, outs}, {22'd0, exp});
  endtask

  task automatic chk_regs(input string tag, input int s, input int f, input logic e);
    chk({tag, "_stall"}, {28'd0, stall_cnt}, s);
    chk({tag, "_flush"}, {28'd0, flush_cnt}, f);
    chk({tag, "_err"}, {31'd0, mem_err}, {31'd0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    idex_memRead = 1'b0; idex_rd = 5'd0;
    exmem_branch = 1'b0; exmem_zf = 1'b0; exmem_jump = 1'b0;
    exmem_memRead = 1'b0; exmem_memWrite = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    chk_outs("reset_outs", O_RST);
    tick(); tick();
    rst = 1'b0;
    chk_regs("after_reset", 0, 0, 1'b0);
    chk_outs("normal", O_NORM);
    tick();

    // Load-use on rs: one bubble, then normal.
    idex_memRead = 1'b1; idex_rd = 5'd8; id_rs = 5'd8;
    chk_outs("lu_rs", O_LU);
    tick();
    chk_regs("lu_rs", 1, 0, 1'b0);
    idex_memRead = 1'b0;
    chk_outs("lu_cleared", O_NORM);
    tick();

    // Register 0 never stalls; rt only counts when used.
    idex_memRead = 1'b1; idex_rd = 5'd0; id_rs = 5'd0;
    chk_outs("lu_r0", O_NORM);
    tick();
    chk_regs("lu_r0", 1, 0, 1'b0);
    idex_rd = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rt = 1'b0;
    chk_outs("lu_rt_unused", O_NORM);
    tick();
    id_uses_rt = 1'b1;
    chk_outs("lu_rt_used", O_LU);
    tick();
    chk_regs("lu_rt_used", 2, 0, 1'b0);

    // Branch taken beats a concurrent load-use.
    exmem_branch = 1'b1; exmem_zf = 1'b1;
    chk_outs("br_over_lu", O_BR);
    tick();
    chk_regs("br", 2, 1, 1'b0);
    clear_inputs();
    exmem_jump = 1'b1; exmem_branch = 1'b1; exmem_zf = 1'b1;
    chk_outs("jump_and_branch", O_JMP);
    tick();
    chk_regs("jump_and_branch", 2, 2, 1'b0);
    exmem_jump = 1'b0; exmem_zf = 1'b0;
    chk_outs("br_not_taken", O_NORM);
    tick();
    clear_inputs();

    // Memory access ready on the first cycle: no hold.
    exmem_memRead = 1'b1; mem_ready = 1'b1;
    chk_outs("mem_fast", O_NORM);
    tick();

    // Memory wait: 3 not-ready cycles, then ready.
    mem_ready = 1'b0;
    chk_outs("wait_c1", O_HOLD);
    tick();
    chk_outs("wait_c2", O_HOLD | 10'd1);
    tick();
    chk_outs("wait_c3", O_HOLD | 10'd1);
    tick();
    mem_ready = 1'b1;
    chk_outs("wait_c4_ready", O_NORM | 10'd1);
    tick();
    chk_regs("wait_done", 5, 2, 1'b0);
    clear_inputs();
    chk_outs("wait_back_run", O_NORM);
    tick();

    // Hold over a pending jump; redirect only on the ready cycle.
    exmem_jump = 1'b1; exmem_memWrite = 1'b1;
    chk_outs("hold_jmp_c1", O_HOLD);
    tick();
    chk_outs("hold_jmp_c2", O_HOLD | 10'd1);
    tick();
    chk_regs("hold_jmp_mid", 7, 2, 1'b0);
    mem_ready = 1'b1;
    chk_outs("hold_jmp_ready", O_JMP | 10'd1);
    tick();
    chk_regs("hold_jmp_done", 7, 3, 1'b0);
    clear_inputs();
    chk_outs("hold_jmp_run", O_NORM);
    tick();

    // Timeout: mem_err set at the end of the 4th MEM_WAIT cycle.
    exmem_memRead = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_err_yet", {31'd0, mem_err}, 32'd0);
    end
    tick();
    chk("err_set", {31'd0, mem_err}, 32'd1);
    tick();
    chk_regs("err_sticky", 13, 3, 1'b1);
    chk_outs("err_still_wait", O_HOLD | 10'd1);

    // Reset mid-wait aborts the wait.
    rst = 1'b1;
    chk_outs("rst_mid_wait", O_RST);
    tick();
    rst = 1'b0;
    clear_inputs();
    chk_regs("rst_cleared", 0, 0, 1'b0);
    chk_outs("rst_run", O_NORM);
    tick();

    // Saturation of both counters at 15.
    idex_memRead = 1'b1; idex_rd = 5'd9; id_rs = 5'd9;
    for (int i = 0; i < 18; i++) tick();
    chk_regs("stall_sat", 15, 0, 1'b0);
    clear_inputs();
    exmem_branch = 1'b1; exmem_zf = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    chk_regs("flush_sat", 15, 15, 1'b0);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
